// File: rtl/sample_read_responder_pkg.sv
// rtl/sample_read_responder_pkg.sv - shared widths, channel index type and requester priority encoder
package sample_read_responder_pkg;

  localparam int AW_DEF = 15;
  localparam int DW_DEF = 16;

  typedef logic [1:0] chan_t;

  // Lowest-numbered active enable wins; the arbiter calls this same function.
  function automatic chan_t prio_encode(input logic [3:0] en);
    chan_t idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en[i]) idx = chan_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sample_read_responder_resp_hold_slot.sv
// rtl/sample_read_responder_resp_hold_slot.sv - one-deep per-channel response hold register with ack and sticky overrun
module resp_hold_slot
  import sample_read_responder_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          resp_valid,
  input  logic [DW-1:0] resp_data,
  input  logic          ack,
  input  logic          clr_overrun,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          overrun
);

  logic slot_free;
  logic lost;

  // An ack on the arrival edge frees the slot for the incoming word.
  assign slot_free = !valid || ack;
  assign lost      = resp_valid && !slot_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (resp_valid) begin
        if (slot_free) begin
          data  <= resp_data;
          valid <= 1'b1;
        end
      end else if (valid && ack) begin
        valid <= 1'b0;
      end

      if (lost) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sample_read_responder.sv
// rtl/sample_read_responder.sv - issues arbitrated sample RAM reads and routes returned words to the winning voice
module sample_read_responder
  import sample_read_responder_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en0,
  input  logic          en1,
  input  logic          en2,
  input  logic          en3,
  input  logic [AW-1:0] ad_in,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] data0,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [DW-1:0] data3,
  output logic          valid0,
  output logic          valid1,
  output logic          valid2,
  output logic          valid3,
  input  logic          ack0,
  input  logic          ack1,
  input  logic          ack2,
  input  logic          ack3,
  output logic [3:0]    overrun,
  input  logic          clr_overrun
);

  logic [3:0]         en_vec;
  logic [3:0]         ack_vec;
  logic [3:0]         valid_vec;
  logic [DW-1:0]      slot_data [4];
  chan_t              tag_q;
  logic               req_q;
  logic [MEM_LAT-1:0] pipe_req;
  chan_t              pipe_tag [MEM_LAT];
  logic               resp_valid;
  chan_t              resp_tag;

  assign en_vec  = {en3, en2, en1, en0};
  assign ack_vec = {ack3, ack2, ack1, ack0};

  // Winner is latched on the same edge the arbiter registers ad_in.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q    <= '0;
      req_q    <= 1'b0;
      pipe_req <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      tag_q       <= prio_encode(en_vec);
      req_q       <= |en_vec;
      pipe_req[0] <= req_q;
      pipe_tag[0] <= tag_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_req[i] <= pipe_req[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign mem_addr   = ad_in;
  assign mem_rd     = req_q;
  assign resp_valid = pipe_req[MEM_LAT-1];
  assign resp_tag   = pipe_tag[MEM_LAT-1];

  for (genvar k = 0; k < 4; k++) begin : g_slot
    resp_hold_slot #(.DW(DW)) u_slot (
      .clock       (clock),
      .reset       (reset),
      .resp_valid  (resp_valid && (resp_tag == chan_t'(k))),
      .resp_data   (mem_data),
      .ack         (ack_vec[k]),
      .clr_overrun (clr_overrun),
      .data        (slot_data[k]),
      .valid       (valid_vec[k]),
      .overrun     (overrun[k])
    );
  end

  assign data0  = slot_data[0];
  assign data1  = slot_data[1];
  assign data2  = slot_data[2];
  assign data3  = slot_data[3];
  assign valid0 = valid_vec[0];
  assign valid1 = valid_vec[1];
  assign valid2 = valid_vec[2];
  assign valid3 = valid_vec[3];

endmodule

// File: tb/tb_sample_read_responder.sv
// tb/tb_sample_read_responder.sv - randomized scoreboard bench for sample_read_responder
module tb_sample_read_responder;

  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int MEM_LAT = 2;

  logic          clock;
  logic          reset;
  logic          en0, en1, en2, en3;
  logic [AW-1:0] ad_in;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          valid0, valid1, valid2, valid3;
  logic          ack0, ack1, ack2, ack3;
  logic [3:0]    overrun;
  logic          clr_overrun;

  sample_read_responder #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .ad_in(ad_in), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic          m_req;
  int            m_tag;
  logic          m_v [4];
  logic [DW-1:0] m_d [4];
  logic [3:0]    m_ovr;
  logic          rd_hist [$];
  logic [AW-1:0] addr_hist [$];
  int            sched_ch [int];
  logic [DW-1:0] sched_d [int];
  logic [DW-1:0] ram [int];
  logic [DW-1:0] exp_q [4][$];

  logic [3:0]    dv, dk;
  logic [DW-1:0] dd [4];
  assign dv = {valid3, valid2, valid1, valid0};
  assign dk = {ack3, ack2, ack1, ack0};
  assign dd[0] = data0;
  assign dd[1] = data1;
  assign dd[2] = data2;
  assign dd[3] = data3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    if (!ram.exists(int'(a))) ram[int'(a)] = DW'($urandom);
    return ram[int'(a)];
  endfunction

  task automatic model_reset();
    m_req = 1'b0;
    m_tag = 0;
    m_ovr = 4'b0;
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
      exp_q[k].delete();
    end
    sched_ch.delete();
    sched_d.delete();
  endtask

  // Consumer side: every handshake must deliver the oldest word accepted on that channel.
  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1 && dk[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL consume%0d at cycle %0d: got %h expected nothing", k, cyc, dd[k]);
        end else begin
          check($sformatf("consume%0d", k), 32'(dd[k]), 32'(exp_q[k].pop_front()));
        end
      end
    end
  end

  task automatic cycle(input logic [3:0] e, input logic [AW-1:0] a, input logic [3:0] k,
                       input logic c, input logic r);
    int win;
    logic ev, lost;
    {en3, en2, en1, en0}     = e;
    ad_in                    = a;
    {ack3, ack2, ack1, ack0} = k;
    clr_overrun              = c;
    reset                    = r;
    if (cyc >= MEM_LAT && rd_hist[cyc-MEM_LAT]) mem_data = ram_rd(addr_hist[cyc-MEM_LAT]);
    else mem_data = DW'($urandom);
    #1;
    check("mem_rd", 32'(mem_rd), 32'(m_req));
    if (m_req) check("mem_addr", 32'(mem_addr), 32'(a));
    rd_hist.push_back(m_req);
    addr_hist.push_back(a);
    if (m_req && !r) begin
      sched_ch[cyc+MEM_LAT+1] = m_tag;
      sched_d[cyc+MEM_LAT+1]  = ram_rd(a);
    end
    win = -1;
    for (int i = 0; i < 4; i++) if (e[i] && win < 0) win = i;
    @(posedge clock);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      m_req = (win >= 0);
      m_tag = (win < 0) ? 0 : win;
      for (int ch = 0; ch < 4; ch++) begin
        ev   = sched_ch.exists(cyc) && sched_ch[cyc] == ch;
        lost = 1'b0;
        if (ev) begin
          if (!m_v[ch] || k[ch]) begin
            m_d[ch] = sched_d[cyc];
            m_v[ch] = 1'b1;
            exp_q[ch].push_back(sched_d[cyc]);
          end else begin
            lost = 1'b1;
          end
        end else if (m_v[ch] && k[ch]) begin
          m_v[ch] = 1'b0;
        end
        m_ovr[ch] = lost ? 1'b1 : (c ? 1'b0 : m_ovr[ch]);
      end
      if (sched_ch.exists(cyc)) begin
        sched_ch.delete(cyc);
        sched_d.delete(cyc);
      end
    end
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("valid%0d", ch), 32'(dv[ch]), 32'(m_v[ch]));
      check($sformatf("data%0d", ch), 32'(dd[ch]), 32'(m_d[ch]));
    end
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n, input logic [3:0] k);
    for (int i = 0; i < n; i++) cycle(4'b0, AW'($urandom), k, 1'b0, 1'b0);
  endtask

  initial begin
    {en3, en2, en1, en0}     = 4'b0;
    {ack3, ack2, ack1, ack0} = 4'b0;
    ad_in = '0; mem_data = '0; clr_overrun = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    cycle(4'b0, '0, 4'b0, 1'b0, 1'b1);
    check("mem_addr_reset", 32'(mem_addr), 32'(0));
    idle(2, 4'b0);

    // Single read to channel 2
    ram[int'(15'h1234)] = 16'hBEEF;
    cycle(4'b0100, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, 15'h1234, 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT + 2, 4'b0);
    check("single_data2", 32'(data2), 32'h0000BEEF);
    idle(1, 4'b0100);

    // Priority: 1 beats 3
    cycle(4'b1010, AW'($urandom), 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT + 3, 4'b0);
    check("prio_valid3", 32'(valid3), 32'(0));
    idle(1, 4'b0010);

    // Back-to-back, RAM content 0xA000 + addr
    for (int i = 0; i < 4; i++) ram[int'(15'h0100 + 15'(i))] = 16'hA100 + 16'(i);
    cycle(4'b0001, AW'($urandom), 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle((i < 3) ? 4'(1 << (i + 1)) : 4'b0, 15'h0100 + 15'(i), 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT + 3, 4'b0);
    check("b2b_overrun", 32'(overrun), 32'(0));
    idle(1, 4'b1111);

    // Overrun on channel 0, then ack coinciding with a third arrival
    cycle(4'b0001, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0001, 15'h0200, 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, 15'h0201, 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT + 3, 4'b0);
    cycle(4'b0001, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, 15'h0202, 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT - 1, 4'b0);
    cycle(4'b0000, AW'($urandom), 4'b0001, 1'b0, 1'b0);
    check("ovr_valid0", 32'(valid0), 32'(1));
    idle(2, 4'b0);

    // Clear racing a new overrun on channel 3
    cycle(4'b1000, AW'($urandom), 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT + 3, 4'b0);
    cycle(4'b1000, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, AW'($urandom), 4'b0, 1'b0, 1'b0);
    idle(MEM_LAT - 1, 4'b0);
    cycle(4'b0000, AW'($urandom), 4'b0, 1'b1, 1'b0);
    check("clr_race", 32'(overrun), 32'h8);
    idle(1, 4'b1111);

    // Reset one cycle after mem_rd
    cycle(4'b0100, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, AW'($urandom), 4'b0, 1'b0, 1'b0);
    cycle(4'b0000, AW'($urandom), 4'b0, 1'b0, 1'b1);
    idle(MEM_LAT + 3, 4'b0);
    check("rst_valid", 32'(dv), 32'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] e, k;
      for (int b = 0; b < 4; b++) begin
        e[b] = ($urandom_range(0, 9) < 3);
        k[b] = ($urandom_range(0, 1) == 1);
      end
      cycle(e, AW'($urandom), k, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(MEM_LAT + 3, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
